bp_bench_ctrl: RTL and testbench

//  Benchmark sequencer for the pipelined core and its branch-predictor variants.
//  - On start, holds the core in reset, releases it, then runs it until a halt instruction or a cycle budget.
//  - Counts cycles, resolved control-flow instrs and mispredictions.
//  - Presents the results on a valid/ready port.
//  - Sits between the bench and the core: drives core reset, observes the core's br_instr, br_miss and fetched-instr taps.

---
 rtl/bp_bench_ctrl.sv | 118 +++++++++++
 tb/tb_bp_bench_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bp_bench_ctrl.sv
// bp_bench_ctrl: benchmark sequencer that resets the core, runs it to halt or budget,
// drains in-flight branches and reports cycle/branch/mispredict counts on a valid/ready port.
module bp_bench_ctrl #(
    parameter int          CNT_W        = 32,
    parameter int          RST_CYCLES   = 4,
    parameter int          DRAIN_CYCLES = 4,
    parameter logic [31:0] HALT_INSN    = 32'h00100073
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] max_cycles_i,
    output logic             core_rst_no,
    input  logic             br_instr_i,
    input  logic             br_miss_i,
    input  logic [31:0]      instr_i,
    output logic             busy_o,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [CNT_W-1:0] res_cycles_o,
    output logic [CNT_W-1:0] res_branches_o,
    output logic [CNT_W-1:0] res_misses_o,
    output logic             res_timeout_o
);
    typedef enum logic [2:0] {IDLE, RESET, RUN, DRAIN, DONE} state_t;

    localparam int PMAX = RST_CYCLES > DRAIN_CYCLES ? RST_CYCLES : DRAIN_CYCLES;
    localparam int PW   = $clog2(PMAX + 1);
    localparam logic [PW-1:0] R_LAST = PW'(RST_CYCLES - 1);
    localparam logic [PW-1:0] D_LAST = PW'(DRAIN_CYCLES == 0 ? 0 : DRAIN_CYCLES - 1);

    state_t           state, state_nxt;
    logic [PW-1:0]    ph, ph_nxt;
    logic [CNT_W-1:0] cyc, br, miss, budget;
    logic [CNT_W-1:0] cyc_nxt, br_nxt, miss_nxt, cyc_inc;
    logic             tmo, tmo_nxt, counting, halt, expire;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && ~&v) ? v + CNT_W'(1) : v;
    endfunction

    assign counting    = state == RUN || state == DRAIN;
    assign cyc_inc     = sat_inc(cyc, 1'b1);
    assign halt        = instr_i == HALT_INSN;
    // budget is checked against the post-increment count so budget=N gives N RUN cycles
    assign expire      = budget != '0 && cyc_inc == budget;
    assign core_rst_no = counting;
    assign busy_o      = state != IDLE;
    assign res_valid_o = state == DONE;

    always_comb begin
        state_nxt = state;
        ph_nxt    = ph;
        tmo_nxt   = tmo;
        cyc_nxt   = counting ? cyc_inc : cyc;
        br_nxt    = counting ? sat_inc(br, br_instr_i) : br;
        miss_nxt  = counting ? sat_inc(miss, br_instr_i & br_miss_i) : miss;
        case (state)
            IDLE: if (start_i) begin
                state_nxt = RESET;
                ph_nxt    = '0;
                tmo_nxt   = 1'b0;
                cyc_nxt   = '0;
                br_nxt    = '0;
                miss_nxt  = '0;
            end
            RESET: begin
                state_nxt = ph == R_LAST ? RUN : RESET;
                ph_nxt    = ph == R_LAST ? '0 : ph + 1'b1;
            end
            RUN: if (halt || expire) begin
                state_nxt = DRAIN_CYCLES == 0 ? DONE : DRAIN;
                tmo_nxt   = ~halt;
            end
            DRAIN: begin
                state_nxt = ph == D_LAST ? DONE : DRAIN;
                ph_nxt    = ph == D_LAST ? '0 : ph + 1'b1;
            end
            DONE: if (res_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= IDLE;
            ph             <= '0;
            tmo            <= 1'b0;
            cyc            <= '0;
            br             <= '0;
            miss           <= '0;
            budget         <= '0;
            res_cycles_o   <= '0;
            res_branches_o <= '0;
            res_misses_o   <= '0;
            res_timeout_o  <= 1'b0;
        end else begin
            state <= state_nxt;
            ph    <= ph_nxt;
            tmo   <= tmo_nxt;
            cyc   <= cyc_nxt;
            br    <= br_nxt;
            miss  <= miss_nxt;
            if (state == IDLE && start_i) begin
                budget         <= max_cycles_i;
                res_cycles_o   <= '0;
                res_branches_o <= '0;
                res_misses_o   <= '0;
                res_timeout_o  <= 1'b0;
            end else if (state_nxt == DONE && state != DONE) begin
                res_cycles_o   <= cyc_nxt;
                res_branches_o <= br_nxt;
                res_misses_o   <= miss_nxt;
                res_timeout_o  <= tmo_nxt;
            end
        end
    end
endmodule

// File: tb/tb_bp_bench_ctrl.sv
// tb_bp_bench_ctrl: directed runs with a result scoreboard; a 4-bit-counter instance
// covers saturation.
module tb_bp_bench_ctrl;
    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] HALT = 32'h00100073;

    typedef struct {
        logic [31:0] c, b, m;
        logic        t;
    } exp_t;

    logic        clk = 0, rst = 1, start = 0, start4 = 0;
    logic        br_instr = 0, br_miss = 0, res_ready = 1;
    logic [31:0] max_cycles = 0, instr = NOP;
    logic [3:0]  max4 = 0;

    logic        core_rst_n, busy, res_valid, res_timeout;
    logic [31:0] res_cycles, res_branches, res_misses;
    logic        core_rst_n4, busy4, res_valid4, res_timeout4;
    logic [3:0]  res_cycles4, res_branches4, res_misses4;

    exp_t q0[$], q4[$];
    exp_t e0, e4;
    int   compared = 0, mismatched = 0;

    bp_bench_ctrl u0 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .max_cycles_i(max_cycles),
        .core_rst_no(core_rst_n), .br_instr_i(br_instr), .br_miss_i(br_miss),
        .instr_i(instr), .busy_o(busy), .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res_cycles_o(res_cycles), .res_branches_o(res_branches),
        .res_misses_o(res_misses), .res_timeout_o(res_timeout)
    );

    bp_bench_ctrl #(.CNT_W(4)) u4 (
        .clk_i(clk), .rst_i(rst), .start_i(start4), .max_cycles_i(max4),
        .core_rst_no(core_rst_n4), .br_instr_i(br_instr), .br_miss_i(br_miss),
        .instr_i(instr), .busy_o(busy4), .res_valid_o(res_valid4), .res_ready_i(res_ready),
        .res_cycles_o(res_cycles4), .res_branches_o(res_branches4),
        .res_misses_o(res_misses4), .res_timeout_o(res_timeout4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (q0.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL u0 unexpected result: got cycles %0d expected none", res_cycles);
            end else begin
                e0 = q0.pop_front();
                chk("u0 cycles", res_cycles, e0.c);
                chk("u0 branches", res_branches, e0.b);
                chk("u0 misses", res_misses, e0.m);
                chk("u0 timeout", {31'b0, res_timeout}, {31'b0, e0.t});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && res_valid4 && res_ready) begin
            if (q4.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL u4 unexpected result: got cycles %0d expected none", res_cycles4);
            end else begin
                e4 = q4.pop_front();
                chk("u4 cycles", {28'b0, res_cycles4}, e4.c);
                chk("u4 branches", {28'b0, res_branches4}, e4.b);
                chk("u4 misses", {28'b0, res_misses4}, e4.m);
                chk("u4 timeout", {31'b0, res_timeout4}, {31'b0, e4.t});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic b, input logic m);
        instr = i;
        br_instr = b;
        br_miss = m;
        step();
        instr = NOP;
        br_instr = 0;
        br_miss = 0;
    endtask

    task automatic nops(input int n);
        repeat (n) drive(NOP, 0, 0);
    endtask

    // returns in the first RUN cycle; checks the core was held in reset exactly 4 cycles
    task automatic begin_run(input bit sel, input logic [31:0] b);
        int n = 0;
        if (sel) begin
            start4 = 1;
            max4 = b[3:0];
        end else begin
            start = 1;
            max_cycles = b;
        end
        step();
        start = 0;
        start4 = 0;
        while (!(sel ? core_rst_n4 : core_rst_n) && n < 50) begin
            step();
            n++;
        end
        chk(sel ? "u4 reset length" : "u0 reset length", n, 4);
    endtask

    task automatic wait_idle(input bit sel);
        int n = 0;
        while ((sel ? busy4 : busy) && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) begin
            compared++;
            mismatched++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", n);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        step();
        chk("reset core_rst_no", {31'b0, core_rst_n}, 0);
        chk("reset busy", {31'b0, busy}, 0);
        chk("reset valid", {31'b0, res_valid}, 0);
        chk("reset cycles", res_cycles, 0);
        step();
        rst = 0;
        step();

        // halt on 10th RUN cycle, unlimited budget
        q0.push_back('{32'd14, 32'd0, 32'd0, 1'b0});
        begin_run(0, 0);
        nops(9);
        drive(HALT, 0, 0);
        wait_idle(0);

        // budget expiry with branches and misses
        q0.push_back('{32'd24, 32'd6, 32'd2, 1'b1});
        begin_run(0, 20);
        for (int i = 0; i < 20; i++) drive(NOP, i < 6, i == 1 || i == 4);
        wait_idle(0);

        // halt and budget together; lone br_miss ignored; drain counts branch, ignores halt
        q0.push_back('{32'd12, 32'd2, 32'd1, 1'b0});
        begin_run(0, 8);
        nops(2);
        drive(NOP, 0, 1);
        nops(1);
        drive(NOP, 1, 1);
        nops(2);
        drive(HALT, 0, 0);
        drive(NOP, 1, 0);
        drive(HALT, 0, 0);
        wait_idle(0);

        // backpressure in DONE, start in DONE ignored
        res_ready = 0;
        q0.push_back('{32'd7, 32'd0, 32'd0, 1'b0});
        begin_run(0, 0);
        nops(2);
        drive(HALT, 0, 0);
        n = 0;
        while (!res_valid && n < 20) begin
            step();
            n++;
        end
        for (int i = 0; i < 8; i++) begin
            chk("hold valid", {31'b0, res_valid}, 1);
            chk("hold cycles", res_cycles, 7);
            chk("hold timeout", {31'b0, res_timeout}, 0);
            if (i == 3) start = 1;
            if (i == 4) start = 0;
            step();
        end
        res_ready = 1;
        step();
        chk("accept valid", {31'b0, res_valid}, 0);
        chk("accept busy", {31'b0, busy}, 0);
        step();
        chk("start not queued", {31'b0, busy}, 0);

        // async reset mid-RUN
        begin_run(0, 0);
        drive(NOP, 1, 1);
        nops(2);
        #3 rst = 1;
        #1;
        chk("abort core_rst_no", {31'b0, core_rst_n}, 0);
        chk("abort busy", {31'b0, busy}, 0);
        chk("abort valid", {31'b0, res_valid}, 0);
        chk("abort branches", res_branches, 0);
        @(posedge clk);
        #1 rst = 0;
        step();
        q0.push_back('{32'd9, 32'd1, 32'd1, 1'b1});
        begin_run(0, 5);
        drive(NOP, 1, 1);
        nops(4);
        wait_idle(0);

        // 4-bit counters saturate
        q4.push_back('{32'd15, 32'd15, 32'd3, 1'b0});
        begin_run(1, 0);
        for (int i = 0; i < 20; i++) drive(NOP, 1, i < 3);
        drive(HALT, 0, 0);
        wait_idle(1);

        step();
        chk("u0 queue drained", q0.size(), 0);
        chk("u4 queue drained", q4.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
